// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vm_pkg
//  Description : Product codes and dispenser state encoding shared by the
//                vending machine blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package vm_pkg;

    localparam logic [1:0] PROD_NONE  = 2'b00;
    localparam logic [1:0] PROD_CHOC  = 2'b01;
    localparam logic [1:0] PROD_DRINK = 2'b10;
    localparam logic [1:0] PROD_BAD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MOTOR  = 3'd1,
        ST_EJECT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } disp_state_t;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/vm_dispenser_if.sv
`default_nettype none
// ============================================================================
//  Module      : vm_dispenser_if
//  Description : Controller/sensor side and actuator/status side of the
//                dispenser stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface vm_dispenser_if;

    logic       done;
    logic [1:0] product;
    logic [1:0] change;
    logic       drop_sense;
    logic       motor_choc;
    logic       motor_drink;
    logic       coin_eject;
    logic       busy;
    logic       vend_ok;
    logic       jam;
    logic       overrun;
    logic       bad_code;

    modport master (
        output done, product, change, drop_sense,
        input  motor_choc, motor_drink, coin_eject, busy,
               vend_ok, jam, overrun, bad_code
    );

    modport slave (
        input  done, product, change, drop_sense,
        output motor_choc, motor_drink, coin_eject, busy,
               vend_ok, jam, overrun, bad_code
    );

endinterface : vm_dispenser_if
`default_nettype wire

// File: rtl/vm_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vm_pulse_timer
//  Description : Loadable down-counter; expire_o flags the last cycle of a
//                len_i-cycle interval started by load_i.
//  Revision    : 1.0  initial release
// ============================================================================
module vm_pulse_timer #(
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] len_i,
    output logic                  expire_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= len_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule : vm_pulse_timer
`default_nettype wire

// File: rtl/vm_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : vm_dispenser
//  Description : Drives product motors and coin ejector after a vend, with
//                jam supervision; all outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module vm_dispenser
    import vm_pkg::*;
#(
    parameter int MOTOR_TIMEOUT = 16,
    parameter int EJECT_CYCLES  = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int CNT_W         = 5
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    vm_dispenser_if.slave  bus
);

    disp_state_t      state_q, state_d;
    logic [1:0]       prod_q, prod_d;
    logic [1:0]       coins_q, coins_d;
    logic             w_timeout;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_len;
    logic             w_tmr_expire;

    logic motor_choc_q, motor_drink_q, coin_eject_q, busy_q;
    logic vend_ok_q, jam_q, overrun_q, bad_code_q;

    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        coins_d   = coins_q;
        w_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.done) begin
                    prod_d  = bus.product;
                    coins_d = bus.change;
                    if (bus.product == PROD_CHOC || bus.product == PROD_DRINK)
                        state_d = ST_MOTOR;
                    else if (bus.change != 2'd0)
                        state_d = ST_EJECT;
                    else
                        state_d = ST_FINISH;
                end
            end
            ST_MOTOR: begin
                if (bus.drop_sense || w_tmr_expire) begin
                    w_timeout = !bus.drop_sense;
                    state_d   = (coins_q != 2'd0) ? ST_EJECT : ST_FINISH;
                end
            end
            ST_EJECT: begin
                if (w_tmr_expire) begin
                    if (coins_q != 2'd0)
                        coins_d = coins_q - 2'd1;
                    state_d = (coins_q > 2'd1) ? ST_GAP : ST_FINISH;
                end
            end
            ST_GAP: begin
                if (w_tmr_expire)
                    state_d = ST_EJECT;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every state change restarts the timer with the target state's length.
    always_comb begin
        w_tmr_load = (state_d != state_q);
        case (state_d)
            ST_MOTOR: w_tmr_len = CNT_W'(MOTOR_TIMEOUT);
            ST_EJECT: w_tmr_len = CNT_W'(EJECT_CYCLES);
            ST_GAP:   w_tmr_len = CNT_W'(GAP_CYCLES);
            default:  w_tmr_len = '0;
        endcase
    end

    vm_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_tmr_load),
        .len_i    (w_tmr_len),
        .expire_o (w_tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            prod_q        <= PROD_NONE;
            coins_q       <= 2'd0;
            motor_choc_q  <= 1'b0;
            motor_drink_q <= 1'b0;
            coin_eject_q  <= 1'b0;
            busy_q        <= 1'b0;
            vend_ok_q     <= 1'b0;
            jam_q         <= 1'b0;
            overrun_q     <= 1'b0;
            bad_code_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prod_q        <= prod_d;
            coins_q       <= coins_d;
            motor_choc_q  <= (state_d == ST_MOTOR) && (prod_d == PROD_CHOC);
            motor_drink_q <= (state_d == ST_MOTOR) && (prod_d == PROD_DRINK);
            coin_eject_q  <= (state_d == ST_EJECT);
            busy_q        <= (state_d != ST_IDLE);
            vend_ok_q     <= (state_d == ST_FINISH);
            jam_q         <= jam_q | w_timeout;
            overrun_q     <= overrun_q | (bus.done && (state_q != ST_IDLE));
            bad_code_q    <= bus.done && (state_q == ST_IDLE) && (bus.product == PROD_BAD);
        end
    end

    assign bus.motor_choc  = motor_choc_q;
    assign bus.motor_drink = motor_drink_q;
    assign bus.coin_eject  = coin_eject_q;
    assign bus.busy        = busy_q;
    assign bus.vend_ok     = vend_ok_q;
    assign bus.jam         = jam_q;
    assign bus.overrun     = overrun_q;
    assign bus.bad_code    = bad_code_q;

endmodule : vm_dispenser
`default_nettype wire

// File: tb/tb_vm_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vm_dispenser
//  Description : Directed self-checking bench for the vending dispenser stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vm_dispenser;
    import vm_pkg::*;

    logic clk;
    logic rst_n;

    vm_dispenser_if bus ();

    vm_dispenser #(
        .MOTOR_TIMEOUT (16),
        .EJECT_CYCLES  (4),
        .GAP_CYCLES    (2),
        .CNT_W         (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // per-transaction statistics gathered by run_monitor
    int s_busy, s_choc, s_drink, s_eject_hi, s_pulses;
    int s_wmin, s_wmax, s_gmin, s_gmax, s_vend, s_bad, s_both;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.done       = 1'b0;
        bus.product    = 2'b00;
        bus.change     = 2'b00;
        bus.drop_sense = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where done has been removed.
    task automatic send(input logic [1:0] p, input logic [1:0] c);
        bus.done    = 1'b1;
        bus.product = p;
        bus.change  = c;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    // Samples every negedge while busy; returns at the first idle negedge.
    task automatic run_monitor(input int drop_at, input bit inject);
        int motor_cyc = 0;
        int run = 0;
        int gap = 0;
        int cyc = 0;
        bit injected = 1'b0;
        s_busy = 0; s_choc = 0; s_drink = 0; s_eject_hi = 0; s_pulses = 0;
        s_wmin = 99; s_wmax = 0; s_gmin = 99; s_gmax = 0;
        s_vend = 0; s_bad = 0; s_both = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            s_busy++;
            if (bus.vend_ok)  s_vend++;
            if (bus.bad_code) s_bad++;
            if (bus.motor_choc)  s_choc++;
            if (bus.motor_drink) s_drink++;
            if (bus.motor_choc && bus.motor_drink) s_both++;
            if (bus.motor_choc || bus.motor_drink) begin
                motor_cyc++;
                bus.drop_sense = (motor_cyc == drop_at);
            end else begin
                bus.drop_sense = 1'b0;
            end
            if (bus.coin_eject) begin
                s_eject_hi++;
                if (run == 0 && s_pulses > 0) begin
                    if (gap < s_gmin) s_gmin = gap;
                    if (gap > s_gmax) s_gmax = gap;
                end
                run++;
                gap = 0;
            end else begin
                if (run > 0) begin
                    s_pulses++;
                    if (run < s_wmin) s_wmin = run;
                    if (run > s_wmax) s_wmax = run;
                end
                run = 0;
                gap++;
            end
            if (inject && bus.coin_eject && !injected) begin
                injected    = 1'b1;
                bus.done    = 1'b1;
                bus.product = PROD_DRINK;
                bus.change  = 2'd3;
            end else begin
                bus.done = 1'b0;
            end
            @(negedge clk);
        end
        bus.done       = 1'b0;
        bus.drop_sense = 1'b0;
        if (run > 0) begin
            s_pulses++;
            if (run < s_wmin) s_wmin = run;
            if (run > s_wmax) s_wmax = run;
        end
        chk("busy_timeout", int'(cyc >= 200), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        chk("rst_busy",    bus.busy, 0);
        chk("rst_motor",   int'(bus.motor_choc | bus.motor_drink), 0);
        chk("rst_eject",   bus.coin_eject, 0);
        chk("rst_flags",   int'({bus.vend_ok, bus.jam, bus.overrun, bus.bad_code}), 0);

        // Asynchronous reset while the chocolate motor runs
        send(PROD_CHOC, 2'd0);
        @(negedge clk);
        chk("mid_motor_on", bus.motor_choc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_motor", bus.motor_choc, 0);
        chk("arst_busy",  bus.busy, 0);
        chk("arst_jam",   bus.jam, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", bus.busy, 0);

        // Chocolate, no change, drop on 3rd motor cycle
        send(PROD_CHOC, 2'd0);
        run_monitor(3, 1'b0);
        chk("t2_choc",  s_choc, 3);
        chk("t2_drink", s_drink, 0);
        chk("t2_eject", s_eject_hi, 0);
        chk("t2_busy",  s_busy, 4);
        chk("t2_vend",  s_vend, 1);
        chk("t2_jam",   bus.jam, 0);

        // Drink, three coins, drop never arrives
        @(negedge clk);
        send(PROD_DRINK, 2'd3);
        run_monitor(0, 1'b0);
        chk("t3_drink",  s_drink, 16);
        chk("t3_choc",   s_choc, 0);
        chk("t3_jam",    bus.jam, 1);
        chk("t3_pulses", s_pulses, 3);
        chk("t3_wmin",   s_wmin, 4);
        chk("t3_wmax",   s_wmax, 4);
        chk("t3_gmin",   s_gmin, 2);
        chk("t3_gmax",   s_gmax, 2);
        chk("t3_vend",   s_vend, 1);
        chk("t3_busy",   s_busy, 33);

        // Illegal product with two coins
        @(negedge clk);
        send(PROD_BAD, 2'd2);
        run_monitor(0, 1'b0);
        chk("t4_bad",    s_bad, 1);
        chk("t4_motor",  s_choc + s_drink, 0);
        chk("t4_pulses", s_pulses, 2);
        chk("t4_busy",   s_busy, 11);
        chk("t4_vend",   s_vend, 1);
        chk("t4_jam_sticky", bus.jam, 1);
        chk("t4_bad_gone", bus.bad_code, 0);

        // Empty transaction
        @(negedge clk);
        send(PROD_NONE, 2'd0);
        run_monitor(0, 1'b0);
        chk("t5_busy", s_busy, 1);
        chk("t5_vend", s_vend, 1);
        chk("t5_bad",  s_bad, 0);

        // done during EJECT is discarded and flagged
        @(negedge clk);
        send(PROD_CHOC, 2'd1);
        run_monitor(1, 1'b1);
        chk("t6_choc",    s_choc, 1);
        chk("t6_drink",   s_drink, 0);
        chk("t6_pulses",  s_pulses, 1);
        chk("t6_width",   s_wmax, 4);
        chk("t6_busy",    s_busy, 6);
        chk("t6_vend",    s_vend, 1);
        chk("t6_overrun", bus.overrun, 1);
        repeat (3) @(negedge clk);
        chk("t6_no_second", int'(bus.busy | bus.vend_ok | bus.motor_drink), 0);
        chk("t6_sticky",  bus.overrun, 1);
        chk("t6_never_both", s_both, 0);

        // Back-to-back: new done in the first idle cycle
        do_reset();
        chk("t7_ovr_clear", bus.overrun, 0);
        send(PROD_NONE, 2'd1);
        run_monitor(0, 1'b0);
        chk("t7a_busy",   s_busy, 5);
        chk("t7a_pulses", s_pulses, 1);
        send(PROD_CHOC, 2'd0);
        run_monitor(2, 1'b0);
        chk("t7b_choc",    s_choc, 2);
        chk("t7b_busy",    s_busy, 3);
        chk("t7b_vend",    s_vend, 1);
        chk("t7b_overrun", bus.overrun, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_vm_dispenser
`default_nettype wire
